dmem_io: RTL and testbench
==========================

// Module: dmem_io
// PURPOSE
//  Data-side memory subsystem directly downstream of the single-cycle ARM core.
//  Consumes the core's MemWrite/ALUResult/WriteData and returns ReadData in the same cycle.
//  Holds the word-addressed data RAM and memory-mapped I/O:
//   - byte TX FIFO with valid/ready drain port
//   - LED register
//   - cycle counter (optional)
// PARAMETERS
//  RAM_WORDS   64  data RAM depth in 32-bit words; power of 2
//  FIFO_DEPTH  8   TX FIFO entries; power of 2, 2..128
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high
//  MemWrite   in   1   store enable from core
//  ALUResult  in   32  byte address from core
//  WriteData  in   32  store data from core
//  ReadData   out  32  load data to core; combinational from ALUResult
//  tx_data    out  8   FIFO head byte
//  tx_valid   out  1   FIFO non-empty
//  tx_ready   in   1   consumer accepts head when tx_valid & tx_ready
//  led        out  8   LED register
// BEHAVIOUR
//  Address decode (ALUResult[1:0] ignored, word accesses only):
//   - ALUResult[31]=0: RAM at index ALUResult[log2(RAM_WORDS)+1:2]
//     * bits [30:log2+2] ignored; RAM aliases across the space
//   - 0x8000_0000 TXDATA  W: push WriteData[7:0]; R: 0
//   - 0x8000_0004 STATUS  R: [0] empty, [1] full, [2] overflow (sticky), [15:8] count, others 0
//                         W: any write clears overflow
//   - 0x8000_0008 LED     R/W bits [7:0]; upper read bits 0
//   - 0x8000_000C CYCLES  see CONFIGURATION
//   - other 0x8xxx_xxxx: read 0, write ignored
//  Timing:
//   - Reads are combinational (zero latency); the core is single-cycle.
//   - Writes take effect at the rising edge where MemWrite=1.
//   - ReadData reflects pre-edge state.
//  Reset values:
//   - FIFO empty: tx_valid=0, count=0; tx_data = don't-care while tx_valid=0
//   - led=0, overflow=0, CYCLES=0
//   - RAM contents are not reset
//  FIFO:
//   - Pop when tx_valid & tx_ready; tx_data stable while tx_valid & !tx_ready.
//   - Push accepted if count<FIFO_DEPTH, or if a pop occurs the same cycle (full + push + pop: count unchanged).
//   - Push while full and no pop: byte dropped, overflow set.
//   - Push to an empty FIFO: tx_valid rises next cycle; no same-cycle bypass.
//   - Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
//  Reset asserted mid-operation:
//   - FIFO, led, overflow and CYCLES return to reset values at that edge.
//   - The concurrent write is discarded; a concurrent RAM write still completes.
// CONFIGURATION
//  Macro DMEM_IO_CYCLES_EN.
//  Defined:
//   - CYCLES is a free-running 32-bit counter, +1 per cycle, wraps 0xFFFF_FFFF->0.
//   - Write loads WriteData; the counter then resumes +1 from that value.
//   - Read returns the current value.
//  Undefined:
//   - No counter logic; CYCLES reads 0, writes ignored.
// STRUCTURE
//  Package dmem_io_pkg:
//   - address constants (IO_BASE, TXDATA/STATUS/LED/CYCLES offsets)
//   - STATUS bit-index localparams
//  Sub-module tx_fifo:
//   - parameterised sync FIFO: push/pop/full/empty/count
//   - drop-on-full handled in dmem_io
// TESTING
//  1. RAM: store 0xDEADBEEF @0x10, load 0x10 -> 0xDEADBEEF; load 0x10+RAM_WORDS*4 -> same (alias).
//  2. FIFO: push 0x41,0x42,0x43 with tx_ready=0 -> STATUS count=3, tx_data=0x41;
//     raise tx_ready -> bytes 0x41,0x42,0x43 out on consecutive cycles, then empty=1.
//  3. Overflow: 9 pushes with tx_ready=0 (depth 8) -> full=1, overflow=1, 9th byte absent;
//     write STATUS -> overflow=0.
//  4. Full + push + pop same cycle -> count stays 8; new byte emerges last.
//  5. LED write 0x1A5 -> led=0xA5, read 0x8000_0008 = 0x000000A5;
//     reset mid-drain -> led=0, tx_valid=0 next cycle.
//  6. DMEM_IO_CYCLES_EN: write CYCLES 0xFFFFFFFE -> reads 0xFFFFFFFF, then 0x0 on following cycles;
//     macro undefined -> read 0.

Source files
------------

// File: rtl/dmem_io_pkg.sv
// rtl/dmem_io_pkg.sv - address map and STATUS layout shared by the dmem_io block
// Purpose: I/O address constants, STATUS bit positions and an address-match helper.
// Ports: none (package).
package dmem_io_pkg;

  localparam logic [31:0] IO_BASE    = 32'h8000_0000;
  localparam logic [31:0] OFF_TXDATA = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFF_LED    = 32'h0000_0008;
  localparam logic [31:0] OFF_CYCLES = 32'h0000_000C;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;

  // Word-granular match against one I/O register; byte offset bits are ignored.
  function automatic logic io_match(input logic [31:0] addr, input logic [31:0] off);
    logic [31:0] reg_addr;
    reg_addr = IO_BASE | off;
    return addr[31:2] == reg_addr[31:2];
  endfunction

endpackage

// File: rtl/dmem_io_tx_fifo.sv
// rtl/dmem_io_tx_fifo.sv - synchronous byte FIFO feeding the TX drain port
// Purpose: DEPTH-entry byte queue; caller guarantees no push when full without pop
//          and no pop when empty.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   enqueue one byte
//   pop               dequeue head
//   head_data         current head byte (valid while !empty)
//   empty, full       occupancy flags
//   count             entries held, width log2(DEPTH)+1
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset. On full+push+pop the write lands in the slot being
  // vacated, which the read pointer reaches last.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      buf_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = buf_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;

endmodule

// File: rtl/dmem_io.sv
// rtl/dmem_io.sv - data RAM plus memory-mapped TX FIFO, LED and cycle counter
// Purpose: data-side memory for a single-cycle core; combinational loads,
//          stores at the rising edge. Optional CYCLES counter: DMEM_IO_CYCLES_EN.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   MemWrite               store enable
//   ALUResult              byte address
//   WriteData / ReadData   store data / combinational load data
//   tx_data, tx_valid      FIFO head byte and non-empty flag
//   tx_ready               consumer accepts head on tx_valid & tx_ready
//   led                    LED register
module dmem_io
  import dmem_io_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  led
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic sel_ram, sel_tx, sel_status, sel_led, sel_cycles;
  assign sel_ram    = ~ALUResult[31];
  assign sel_tx     = io_match(ALUResult, OFF_TXDATA);
  assign sel_status = io_match(ALUResult, OFF_STATUS);
  assign sel_led    = io_match(ALUResult, OFF_LED);
  assign sel_cycles = io_match(ALUResult, OFF_CYCLES);

  // RAM: upper address bits ignored, so the array aliases across the low half.
  logic [31:0]       ram_q [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  assign ram_idx = ALUResult[RAM_AW+1:2];

  // RAM writes are deliberately outside reset.
  always_ff @(posedge clk) begin
    if (MemWrite && sel_ram) begin
      ram_q[ram_idx] <= WriteData;
    end
  end

  logic             wr_tx, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign wr_tx     = MemWrite & sel_tx;
  assign tx_valid  = ~fifo_empty;
  assign fifo_pop  = tx_valid & tx_ready;
  // A pop frees a slot in the same cycle, so a push to a full FIFO still fits.
  assign fifo_push = wr_tx & (~fifo_full | fifo_pop);

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (WriteData[7:0]),
    .pop       (fifo_pop),
    .head_data (tx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  logic [7:0] led_q, led_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    led_d = led_q;
    ovf_d = ovf_q;
    if (MemWrite && sel_led) begin
      led_d = WriteData[7:0];
    end
    if (MemWrite && sel_status) begin
      ovf_d = 1'b0;
    end else if (wr_tx && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  logic [31:0] cycles_rd;
`ifdef DMEM_IO_CYCLES_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q + 32'd1;
    if (MemWrite && sel_cycles) begin
      cycles_d = WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles_rd = cycles_q;
`else
  assign cycles_rd = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      led_q <= led_d;
      ovf_q <= ovf_d;
    end
  end

  assign led = led_q;

  logic [31:0] status_rd;
  always_comb begin
    status_rd                         = '0;
    status_rd[STAT_EMPTY]             = fifo_empty;
    status_rd[STAT_FULL]              = fifo_full;
    status_rd[STAT_OVF]               = ovf_q;
    status_rd[STAT_CNT_LSB +: CNT_W]  = fifo_count;
  end

  always_comb begin
    ReadData = '0;
    if (sel_ram) begin
      ReadData = ram_q[ram_idx];
    end else if (sel_status) begin
      ReadData = status_rd;
    end else if (sel_led) begin
      ReadData = {24'd0, led_q};
    end else if (sel_cycles) begin
      ReadData = cycles_rd;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ALUResult[1:0], sel_cycles};

endmodule

// File: tb/tb_dmem_io.sv
// tb/tb_dmem_io.sv - directed self-checking bench for dmem_io
module tb_dmem_io;

  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_LED = 32'h8000_0008;
  localparam logic [31:0] A_CYC = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset, MemWrite, tx_valid, tx_ready;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic [7:0]  tx_data, led;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_io #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .led       (led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ALUResult = a;
    WriteData = d;
    MemWrite  = 1'b1;
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ALUResult = a;
    #1;
    check(tag, ReadData, exp);
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; ALUResult = '0; WriteData = '0; tx_ready = 1'b0;
    step();
    step();
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_led", {24'd0, led}, 32'd0);
    rd_chk("rst_status", A_ST, 32'h0000_0001);
    rd_chk("rst_cycles", A_CYC, 32'h0);
    reset = 1'b0;
    step();

    // RAM store/load and aliasing
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_alias_depth", 32'h0000_0110, 32'hDEAD_BEEF);
    rd_chk("ram_alias_hi", 32'h4000_0012, 32'hDEAD_BEEF);

    // FIFO: no bypass, ordered drain
    ALUResult = A_TX; WriteData = 32'h41; MemWrite = 1'b1;
    #1;
    check("no_bypass", {31'd0, tx_valid}, 32'd0);
    step();
    MemWrite = 1'b0;
    check("valid_after_push", {31'd0, tx_valid}, 32'd1);
    wr(A_TX, 32'h42);
    wr(A_TX, 32'h43);
    rd_chk("status_cnt3", A_ST, 32'h0000_0300);
    rd_chk("txdata_reads0", A_TX, 32'h0);
    check("head_41", {24'd0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    #1;
    check("drain_0", {24'd0, tx_data}, 32'h41);
    step();
    check("drain_1", {24'd0, tx_data}, 32'h42);
    step();
    check("drain_2", {24'd0, tx_data}, 32'h43);
    step();
    check("drained_valid", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    rd_chk("status_empty", A_ST, 32'h0000_0001);

    // Overflow: 9 pushes into depth 8
    for (int i = 0; i < 9; i++) wr(A_TX, 32'h50 + i);
    rd_chk("status_full_ovf", A_ST, 32'h0000_0806);
    wr(A_ST, 32'h0);
    rd_chk("status_ovf_clr", A_ST, 32'h0000_0802);
    check("full_head", {24'd0, tx_data}, 32'h50);

    // Full + push + pop in one cycle
    ALUResult = A_TX; WriteData = 32'h60; MemWrite = 1'b1; tx_ready = 1'b1;
    step();
    MemWrite = 1'b0; tx_ready = 1'b0;
    rd_chk("status_pushpop", A_ST, 32'h0000_0802);
    check("pushpop_head", {24'd0, tx_data}, 32'h51);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp_drain_%0d", i), {24'd0, tx_data}, (i < 7) ? (32'h51 + i) : 32'h60);
      step();
    end
    check("pp_empty", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // LED, unmapped I/O, reset mid-drain
    wr(A_LED, 32'h0000_01A5);
    check("led_out", {24'd0, led}, 32'hA5);
    rd_chk("led_read", A_LED, 32'h0000_00A5);
    wr(32'h8000_0010, 32'hFFFF_FFFF);
    check("unmapped_wr", {24'd0, led}, 32'hA5);
    rd_chk("unmapped_rd", 32'h8000_0010, 32'h0);
    wr(A_TX, 32'h70);
    wr(A_TX, 32'h71);
    tx_ready = 1'b1;
    step();
    check("mid_drain", {24'd0, tx_data}, 32'h71);
    reset = 1'b1;
    wr(A_LED, 32'h77);
    check("rst_mid_led", {24'd0, led}, 32'h0);
    check("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
    wr(32'h0000_0020, 32'h1234_5678);
    reset = 1'b0; tx_ready = 1'b0;
    rd_chk("ram_wr_in_reset", 32'h0000_0020, 32'h1234_5678);
    rd_chk("status_after_rst", A_ST, 32'h0000_0001);

    // Cycle counter
`ifdef DMEM_IO_CYCLES_EN
    wr(A_CYC, 32'hFFFF_FFFE);
    rd_chk("cyc_load", A_CYC, 32'hFFFF_FFFE);
    step();
    rd_chk("cyc_ff", A_CYC, 32'hFFFF_FFFF);
    step();
    rd_chk("cyc_wrap", A_CYC, 32'h0);
    step();
    rd_chk("cyc_one", A_CYC, 32'h1);
`else
    wr(A_CYC, 32'h0000_0123);
    rd_chk("cyc_off0", A_CYC, 32'h0);
    step();
    rd_chk("cyc_off1", A_CYC, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
